// File: rtl/des_subkey_stream.sv
// rtl/des_subkey_stream.sv - sequential DES round-key streamer, forward (K1..K16) or reverse (K16..K1)
// Optional odd-parity key check enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_subkey_stream (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [47:0] subkey,
  output logic [4:0]  subkey_round,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        last,
  output logic        done,
  output logic        parity_err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // DES numbers bits MSB-first from 1, so DES bit n lives at vector index width-n.
  function automatic logic [55:0] pc1_perm(input logic [63:0] k);
    logic [55:0] res;
    logic [5:0]  idx;
    res = '0;
    for (int i = 0; i < 56; i++) begin
      idx = 6'(64 - PC1[i]);
      res[55 - i] = k[idx];
    end
    return res;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] cd_v);
    logic [47:0] res;
    logic [5:0]  idx;
    res = '0;
    for (int i = 0; i < 48; i++) begin
      idx = 6'(56 - PC2[i]);
      res[47 - i] = cd_v[idx];
    end
    return res;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one; every other round shifts by two.
  function automatic logic shift_two(input logic [4:0] r);
    return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
  endfunction

  state_t      state, next_state;
  logic [55:0] cd;
  logic [4:0]  round;
  logic [4:0]  count;
  logic        mode;
  logic        done_q;
  logic        parity_ok;
  logic        load;
  logic        hs;
  logic [55:0] pc1_key;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic perr_q;

  always_comb begin
    parity_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      parity_ok = parity_ok & (^key_in[8*b +: 8]);
    end
  end

  assign parity_err = perr_q;
`else
  logic unused_parity_bits;

  assign parity_ok          = 1'b1;
  assign parity_err         = 1'b0;
  assign unused_parity_bits = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                                key_in[24], key_in[16], key_in[8], key_in[0]};
`endif

  assign pc1_key      = pc1_perm(key_in);
  assign subkey       = pc2_perm(cd);
  assign subkey_round = round;
  assign done         = done_q;

  always_comb begin
    next_state   = state;
    key_ready    = (state == IDLE);
    subkey_valid = (state == RUN);
    last         = subkey_valid && (count == 5'd15);
    hs           = subkey_valid && subkey_ready;
    load         = key_valid && key_ready && parity_ok;
    case (state)
      IDLE: if (load) next_state = RUN;
      RUN:  if (hs && last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cd     <= '0;
      round  <= '0;
      count  <= '0;
      mode   <= 1'b0;
      done_q <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
      perr_q <= 1'b0;
`endif
    end else begin
      state  <= next_state;
      done_q <= hs && last;
`ifdef DES_KEY_PARITY_CHECK_EN
      perr_q <= key_valid && key_ready && !parity_ok;
`endif
      if (load) begin
        mode  <= decrypt;
        count <= '0;
        // Total shift over 16 rounds is 28, so C16/D16 equals the unrotated PC1 value.
        if (decrypt) begin
          cd    <= pc1_key;
          round <= 5'd16;
        end else begin
          cd    <= {rotl(pc1_key[55:28], 1'b0), rotl(pc1_key[27:0], 1'b0)};
          round <= 5'd1;
        end
      end else if (hs) begin
        if (count != 5'd16) count <= count + 5'd1;
        if (mode) begin
          cd <= {rotr(cd[55:28], shift_two(round)), rotr(cd[27:0], shift_two(round))};
          if (round > 5'd1) round <= round - 5'd1;
        end else begin
          cd <= {rotl(cd[55:28], shift_two(round + 5'd1)),
                 rotl(cd[27:0], shift_two(round + 5'd1))};
          if (round < 5'd16) round <= round + 5'd1;
        end
      end
    end
  end

endmodule
